seq_shifter: RTL
================

Name: seq_shifter

Overview:
Multi-cycle, handshaked variable-amount shifter. It sits directly upstream of the team's fixed-amount combinational shifter stage in the datapath. It accepts an operand plus a run-time shift amount, direction and fill mode, and shifts up to STEP bits per clock until done. It trades latency for area versus a full barrel shifter and presents a registered result with valid/ready backpressure.

Parameters:
BUS, 32, operand/result width in bits (>= 2)
STEP, 4, maximum bits shifted per cycle; power of 2, 1 <= STEP <= BUS
AMT_W, $clog2(BUS), width of shift-amount input (derived, not overridden)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand presented
in_ready  output  1  block can accept an operand this cycle
data_in  input  BUS  operand
shamt  input  AMT_W  shift amount, 0..BUS-1
dirc  input  1  1 = left, 0 = right
arith  input  1  1 = sign-fill on right shift; ignored when dirc=1
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
data_out  output  BUS  shifted result (registered)
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (async, while rst=1): state=IDLE, data_out=0, remaining count=0, out_valid=0, busy=0, in_ready=0 (gated by rst). in_ready returns to 1 the first cycle after rst deasserts.
- Reset mid-operation discards the operation; no partial result appears.
- FSM states:
  - IDLE: in_ready=1. Accept edge (in_valid & in_ready) loads data_in into the working register and latches shamt, dirc and arith. Next state is DONE if shamt==0, else SHIFT.
  - SHIFT: in_ready=0. Each edge shifts the working register by k = min(STEP, rem), where rem is the remaining count; rem -= k. When rem <= STEP, next state is DONE.
  - DONE: out_valid=1 and data_out = working register. If out_ready=0, hold data_out stable.
  - DONE with out_ready=1: go to IDLE. However, in_ready=1 in DONE when out_ready=1. If in_valid is also 1, the new operand is accepted on the same edge (back-to-back) and next state follows the IDLE rule.
- Latency: out_valid rises ceil(shamt/STEP) edges after the accept edge, with shamt=0 giving valid in the cycle right after acceptance. Peak throughput is one result per 1+ceil(shamt/STEP) cycles.
- Fill rules:
  - Left shift: zero fill.
  - Right shift with arith=0: zero fill.
  - Right shift with arith=1: replicate the original operand MSB (latched at accept).
- Width and range: all shifts are within BUS bits and bits shifted out are lost. shamt >= BUS cannot occur by width when BUS is a power of 2. Otherwise shamt is saturated to BUS-1.
- Input handling: in_valid while in_ready=0 is ignored; inputs are sampled only on the accept edge. Changes to data_in, shamt, dirc or arith after acceptance have no effect.
- Output timing: no combinational path from data_in to data_out. in_ready depends only on state, rst and out_ready.

Decomposition:
- Shared package shifter_pkg:
  - state enum type (IDLE, SHIFT, DONE), 2-bit encoding
  - direction constants DIR_LEFT=1, DIR_RIGHT=0
- One natural sub-module, shift_step: combinational, BUS-wide.
  - Inputs: operand, amount 0..STEP, dirc, fill bit.
  - Output: operand shifted by amount with the fill applied.
  - Instantiated once; the FSM and counter live in seq_shifter.

Test Plan:
- Left shift (BUS=32, STEP=4): data_in=0x0000_00F1, shamt=5, dirc=1 -> data_out=0x0000_1E20; out_valid 2 edges after accept; busy high throughout.
- Arithmetic right: data_in=0x8000_0010, shamt=31, dirc=0, arith=1 -> data_out=0xFFFF_FFFF after 8 edges. Same operand with arith=0, shamt=4 -> 0x0800_0001 after 1 edge.
- Zero amount: data_in=0xDEAD_BEEF, shamt=0 -> out_valid in the next cycle with data_out=0xDEAD_BEEF; state never visits SHIFT.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE -> data_out and out_valid stable.
  - Then raise out_ready with in_valid=1 (0x1, shamt=8, left) -> both handshakes on the same edge; next result 0x0000_0100.
- Ignored input: pulse in_valid with a different operand during SHIFT -> in_ready=0, no capture, original result unchanged.
- Reset mid-shift: assert rst asynchronously while in SHIFT with shamt=20 -> out_valid=0, data_out=0, busy=0 immediately. After deassert, in_ready=1 next cycle and a fresh operation completes correctly.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and constants for the sequential shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits with a selectable fill bit.
module shift_step
  import shifter_pkg::*;
#(
  parameter  int BUS  = 32,
  parameter  int STEP = 4,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [BUS-1:0] operand_i,
  input  logic [SW-1:0]  amt_i,
  input  logic           dirc_i,
  input  logic           fill_i,
  output logic [BUS-1:0] result_o
);

  // Left shifts always zero-fill; right shifts OR in a mask of fill bits
  // covering the vacated MSB positions.
  always_comb begin
    result_o = '0;
    if (dirc_i == DIR_LEFT)
      result_o = operand_i << amt_i;
    else
      result_o = (operand_i >> amt_i) | (fill_i ? ~({BUS{1'b1}} >> amt_i) : '0);
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle variable-amount shifter with valid/ready handshakes on both
// sides. Shifts at most STEP bits per clock; the result is registered.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter  int BUS   = 32,
  parameter  int STEP  = 4,
  localparam int AMT_W = $clog2(BUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS-1:0]   data_in,
  input  logic [AMT_W-1:0] shamt,
  input  logic             dirc,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS-1:0]   data_out,
  output logic             busy
);

  localparam int SW = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [BUS-1:0]   work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  logic             accept;
  logic [AMT_W-1:0] amt_sat;
  logic [SW-1:0]    k;
  logic [BUS-1:0]   step_res;

  assign accept   = in_valid & in_ready;
  assign data_out = work_q;

  // Clamp out-of-range amounts (only reachable when BUS is not a power of 2).
  always_comb begin
    amt_sat = shamt;
    if (int'(shamt) > BUS - 1) amt_sat = AMT_W'(BUS - 1);
  end

  // Bits to shift this cycle: min(STEP, remaining).
  always_comb begin
    k = SW'(rem_q);
    if (int'(rem_q) >= STEP) k = SW'(STEP);
  end

  shift_step #(.BUS(BUS), .STEP(STEP)) u_step (
    .operand_i (work_q),
    .amt_i     (k),
    .dirc_i    (dir_q),
    .fill_i    (fill_q),
    .result_o  (step_res)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an accept in DONE follows the same rule as in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (amt_sat == '0) ? DONE : SHIFT;
      SHIFT: if (int'(rem_q) <= STEP) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = (amt_sat == '0) ? DONE : SHIFT;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs; in_ready is held low during reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:  in_ready = ~rst;
      SHIFT: busy = 1'b1;
      DONE: begin
        in_ready  = ~rst & out_ready;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: load on accept, otherwise step while shifting.
  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    dir_d  = dir_q;
    fill_d = fill_q;
    if (accept) begin
      work_d = data_in;
      rem_d  = amt_sat;
      dir_d  = dirc;
      // Sign fill is decided once from the original operand MSB.
      fill_d = arith & data_in[BUS-1];
    end else if (state_q == SHIFT) begin
      work_d = step_res;
      rem_d  = rem_q - AMT_W'(k);
    end
  end

  // Datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      rem_q  <= '0;
      dir_q  <= DIR_RIGHT;
      fill_q <= 1'b0;
    end else begin
      work_q <= work_d;
      rem_q  <= rem_d;
      dir_q  <= dir_d;
      fill_q <= fill_d;
    end
  end

endmodule
